// File: rtl/moore_1101_pkg.sv
// Constants and state encoding shared by the 1101 frame transmitter and detector.
package moore_1101_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [3:0] PREAMBLE = 4'b1101;
    localparam int         PRE_LEN  = 4;

    // Bit counter must reach the longest phase: payload, gap or preamble.
    function automatic int cnt_width(input int data_w, input int gap_len);
        int longest;
        longest = (data_w > gap_len) ? data_w : gap_len;
        if (longest < PRE_LEN)
            longest = PRE_LEN;
        return $clog2(longest);
    endfunction

endpackage

// File: rtl/moore_1101_frame_tx_piso_shift.sv
// Parallel-load, shift-left register; exposes the current MSB and the MSB after the next shift.
module piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    output logic              msb,
    output logic              next_msb
);

    logic [DATA_W-1:0] sreg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sreg <= '0;
        else if (load)
            sreg <= data;
        else if (shift)
            sreg <= sreg << 1;
    end

    assign msb = sreg[DATA_W-1];

    // Lets the registered line output present the following bit in the same edge as the shift.
    generate
        if (DATA_W > 1) begin : g_wide
            assign next_msb = sreg[DATA_W-2];
        end else begin : g_single
            assign next_msb = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/moore_1101_frame_tx.sv
// Serial frame transmitter: preamble 1101, MSB-first payload, then GAP idle zeros.
//
//   state | meaning
//   IDLE  | line at 0, tx_ready high, waiting for tx_valid
//   PRE   | sending preamble bits 1,1,0,1
//   DATA  | sending payload, MSB first
//   GAP   | sending GAP trailing zeros before returning to IDLE
module moore_1101_frame_tx #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              x_out,
    output logic              busy,
    output logic              frame_done
);

    import moore_1101_pkg::*;

    localparam int         CNT_W    = cnt_width(DATA_W, GAP);
    localparam logic [1:0] PRE_TOP  = 2'(PRE_LEN - 1);
    localparam logic [1:0] PRE_NEXT = 2'(PRE_LEN - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             sh_load;
    logic             sh_shift;
    logic             sh_msb;
    logic             sh_next_msb;
    logic [1:0]       pre_idx;

    assign accept   = tx_valid && tx_ready;
    assign sh_load  = (state == IDLE) && accept;
    assign sh_shift = (state == DATA);
    assign pre_idx  = PRE_NEXT - cnt[1:0];

    piso_shift #(
        .DATA_W (DATA_W)
    ) u_piso_shift (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (sh_load),
        .shift    (sh_shift),
        .data     (tx_data),
        .msb      (sh_msb),
        .next_msb (sh_next_msb)
    );

    // Outputs are registered alongside the state so each cycle shows the bit of its own state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            x_out      <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= PRE;
                        cnt      <= '0;
                        x_out    <= PREAMBLE[PRE_TOP];
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                PRE: begin
                    if (cnt == CNT_W'(PRE_LEN - 1)) begin
                        state <= DATA;
                        cnt   <= '0;
                        x_out <= sh_msb;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        x_out <= PREAMBLE[pre_idx];
                    end
                end
                DATA: begin
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state <= moore_1101_pkg::GAP;
                        cnt   <= '0;
                        x_out <= 1'b0;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        x_out <= sh_next_msb;
                    end
                end
                moore_1101_pkg::GAP: begin
                    x_out <= 1'b0;
                    if (cnt == CNT_W'(GAP - 1)) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        tx_ready   <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    x_out    <= 1'b0;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moore_1101_frame_tx.sv
// Bench for moore_1101_frame_tx: fixed frame vectors, corner sequences, and random traffic against a bit-queue model.
module tb_moore_1101_frame_tx;

    localparam int DATA_W    = 8;
    localparam int GAP_BITS  = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       x_out;
    logic       busy;
    logic       frame_done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    moore_1101_frame_tx #(
        .DATA_W (DATA_W),
        .GAP    (GAP_BITS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .x_out      (x_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Reference: a frame is a queue of line bits; the cycle after it drains is the done/idle cycle.
    logic       m_line  = 1'b0;
    logic       m_ready = 1'b1;
    logic       m_busy  = 1'b0;
    logic       m_done  = 1'b0;
    logic [3:0] m_pre   = 4'b1101;
    logic       mq[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_line  = 1'b0;
            m_ready = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
        end else begin
            if (!m_busy && tx_valid) begin
                for (int i = 3; i >= 0; i--) mq.push_back(m_pre[i]);
                for (int i = DATA_W - 1; i >= 0; i--) mq.push_back(tx_data[i]);
                for (int i = 0; i < GAP_BITS; i++) mq.push_back(1'b0);
            end
            if (mq.size() > 0) begin
                m_line  = mq.pop_front();
                m_busy  = 1'b1;
                m_ready = 1'b0;
                m_done  = 1'b0;
            end else begin
                m_done  = m_busy;
                m_busy  = 1'b0;
                m_ready = 1'b1;
                m_line  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({x_out, tx_ready, busy, frame_done} !== {m_line, m_ready, m_busy, m_done}) begin
                errors++;
                $display("FAIL model_cycle t=%0t x/rdy/busy/done got=%b%b%b%b want=%b%b%b%b", $time,
                         x_out, tx_ready, busy, frame_done, m_line, m_ready, m_busy, m_done);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(tx_ready), 64'd1);
    endtask

    task automatic start(input logic [7:0] d);
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
    endtask

    task automatic collect(input int n, output logic [63:0] bits, output logic [63:0] dmask);
        bits  = '0;
        dmask = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            bits  = {bits[62:0], x_out};
            dmask = {dmask[62:0], frame_done};
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [13:0] frame;
    } vec_t;

    vec_t        tbl[7];
    logic [63:0] bits;
    logic [63:0] dmask;
    logic [63:0] rmask;
    int          hits;

    initial begin
        #20000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hA5, 14'b1101_10100101_00};
        tbl[1] = '{8'hFF, 14'b1101_11111111_00};
        tbl[2] = '{8'h00, 14'b1101_00000000_00};
        tbl[3] = '{8'h0D, 14'b1101_00001101_00};
        tbl[4] = '{8'h3C, 14'b1101_00111100_00};
        tbl[5] = '{8'h01, 14'b1101_00000001_00};
        tbl[6] = '{8'h80, 14'b1101_10000000_00};

        #1 reset_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({x_out, tx_ready, busy, frame_done}), 64'b0100);
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            start(tbl[k].data);
            collect(16, bits, dmask);
            check($sformatf("frame_%02h", tbl[k].data), bits[15:0], 64'({tbl[k].frame, 2'b00}));
            check($sformatf("done_%02h", tbl[k].data), dmask[15:0], 64'h0002);
        end

        start(8'h0D);
        collect(16, bits, dmask);
        hits = 0;
        for (int k = 0; k <= 12; k++)
            if (bits[15-k -: 4] == 4'b1101) hits++;
        check("loopback_hits", 64'(hits), 64'd2);

        // Back-to-back: valid held, second word accepted in the frame_done cycle.
        start(8'hFF);
        bits  = '0;
        dmask = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1)  tx_data  = 8'h00;
            if (i == 16) tx_valid = 1'b0;
            bits  = {bits[62:0], x_out};
            dmask = {dmask[62:0], frame_done};
        end
        check("b2b_line", bits[29:0], 64'({14'b1101_11111111_00, 1'b0, 14'b1101_00000000_00, 1'b0}));
        check("b2b_done", dmask[29:0], 64'h0000_8001);

        // Reset during payload bit 3 of 8'h5A.
        start(8'h5A);
        collect(8, bits, dmask);
        @(posedge clk);
        #1 check("rst_mid_pre", 64'(x_out), 64'd1);
        #1 reset_n = 1'b0;
        #1 check("rst_mid_out", 64'({x_out, tx_ready, busy, frame_done}), 64'b0100);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        collect(20, bits, dmask);
        check("rst_no_done", dmask[19:0], 64'h0);
        check("rst_quiet_line", bits[19:0], 64'h0);
        start(8'h3C);
        collect(16, bits, dmask);
        check("post_rst_3c", bits[15:0], 64'({14'b1101_00111100_00, 2'b00}));
        check("post_rst_done", dmask[15:0], 64'h0002);

        // Backpressure: data and valid wiggle while busy.
        start(8'h96);
        bits  = '0;
        rmask = '0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            tx_valid = (i < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
            tx_data  = 8'($urandom);
            bits  = {bits[62:0], x_out};
            rmask = {rmask[62:0], tx_ready};
        end
        check("bp_line", bits[15:0], 64'({14'b1101_10010110_00, 2'b00}));
        check("bp_ready", rmask[15:0], 64'h0003);

        // Random traffic with one asynchronous reset, checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            if (i == 311) begin
                @(posedge clk);
                #2 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                @(negedge clk);
            end
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
        end
        tx_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
